// File: rtl/fa_response_checker.sv
// rtl/fa_response_checker.sv - exhaustive 8-vector response checker for an external full adder
//
// Purpose: on start, walks {inA,inB,cin} through 000..111. Each vector is held for
// SETTLE_CYCLES+1 cycles. On the last cycle of each vector, sum/cout are compared
// against the ideal full-adder result. Failures are accumulated into err_count and fail_vec.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   run request, honoured only in IDLE and DONE
//   inA/inB/cin out  registered stimulus to the adder under test
//   sum/cout   in   responses from the adder under test
//   busy       out  run in progress (SETTLE or CHECK)
//   done       out  results valid (DONE)
//   pass       out  DONE with no failing vector
//   err_count  out  failing vectors in current/last run, 0..8
//   fail_vec   out  bit k set when vector k failed
//
// SETTLE_CYCLES legal range is 1..15.

module fa_response_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       inA,
   output logic       inB,
   output logic       cin,
   input  logic       sum,
   input  logic       cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [7:0] fail_vec
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] vec_q, vec_d;
   logic [3:0] wait_q, wait_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [3:0] err_q, err_d;
   logic [7:0] fail_q, fail_d;

   logic       exp_sum;
   logic       exp_cout;
   logic       mismatch;

   // Ideal full-adder reference for the vector currently being driven.
   always_comb begin
      exp_sum  = vec_q[2] ^ vec_q[1] ^ vec_q[0];
      exp_cout = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
      mismatch = (sum != exp_sum) || (cout != exp_cout);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      wait_d  = wait_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fail_d  = fail_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SETTLE;
               idx_d   = 3'd0;
               vec_d   = 3'd0;
               wait_d  = 4'd0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = 4'd0;
               fail_d  = 8'd0;
            end
         end

         SETTLE: begin
            wait_d = wait_q + 4'd1;
            if (wait_q == WAIT_LAST) begin
               state_d = CHECK;
            end
         end

         CHECK: begin
            // A vector is counted once even if both sum and cout are wrong.
            // The guard keeps err_count from wrapping.
            if (mismatch) begin
               fail_d[idx_q] = 1'b1;
               if (err_q < 4'd8) begin
                  err_d = err_q + 4'd1;
               end
            end
            if (idx_q == 3'd7) begin
               state_d = DONE;
               vec_d   = 3'd0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == 4'd0);
            end else begin
               state_d = SETTLE;
               idx_d   = idx_q + 3'd1;
               vec_d   = idx_q + 3'd1;
               wait_d  = 4'd0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         vec_q   <= 3'd0;
         wait_q  <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 4'd0;
         fail_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         wait_q  <= wait_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

   assign inA       = vec_q[2];
   assign inB       = vec_q[1];
   assign cin       = vec_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: doc/fa_response_checker.md
FA_RESPONSE_CHECKER -- requirements
Module: fa_response_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning cycles a vector is held before its response is sampled; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to run the full 8-vector check; sampled in IDLE and DONE only.
REQ-005 inA  output  1  registered stimulus bit A to the full adder under test.
REQ-006 inB  output  1  registered stimulus bit B to the full adder under test.
REQ-007 cin  output  1  registered stimulus carry-in to the full adder under test.
REQ-008 sum  input  1  sum response from the full adder under test.
REQ-009 cout  input  1  carry-out response from the full adder under test.
REQ-010 busy  output  1  high while a run is in progress (SETTLE or CHECK).
REQ-011 done  output  1  high while in DONE; results valid.
REQ-012 pass  output  1  high in DONE when err_count == 0.
REQ-013 err_count  output  4  number of failing vectors in the current or last run, 0..8.
REQ-014 fail_vec  output  8  bit k set when vector k ({inA,inB,cin} = k) failed.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-016 IDLE with start=1: on that edge clear err_count, fail_vec, pass; set vector index to 0; drive {inA,inB,cin}=000; wait counter=0; go to SETTLE.
REQ-017 SETTLE: increment wait counter each cycle; when counter == SETTLE_CYCLES-1, go to CHECK on that edge.
REQ-018 CHECK: one cycle; on its closing edge compare sum against inA^inB^cin and cout against majority(inA,inB,cin).
REQ-019 Mismatch on either bit: err_count += 1 and fail_vec[index] = 1 on the CHECK closing edge; one count per vector max.
REQ-020 CHECK with index < 7: on the same edge increment index, drive new vector on {inA,inB,cin}, clear wait counter, go to SETTLE.
REQ-021 CHECK with index == 7: go to DONE; drive {inA,inB,cin}=000; pass = (final err_count == 0), including vector-7 result.
REQ-022 Each vector held SETTLE_CYCLES+1 cycles; full run = 8*(SETTLE_CYCLES+1) cycles from start edge to DONE entry.
REQ-023 Vectors SHALL be applied in ascending order 000..111, {inA,inB,cin} = index[2:0].
REQ-024 start SHALL be ignored in SETTLE and CHECK; held-high start does not restart a run in progress.
REQ-025 DONE: hold done=1, pass, err_count, fail_vec stable; start=1 restarts exactly as from IDLE (results cleared on that edge).
REQ-026 err_count SHALL not wrap; 8 is the maximum reachable value.
REQ-027 inA, inB, cin, busy, done, pass SHALL be register outputs, glitch-free; no combinational path from sum/cout to any output.

Reset
REQ-028 rst=1 at any edge, including mid-run: state=IDLE, inA=inB=cin=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, index=0, wait counter=0.
REQ-029 rst SHALL take priority over start and all FSM transitions on the same edge.

Verification
REQ-030 Ideal combinational adder model, SETTLE_CYCLES=2, one-cycle start pulse -> vectors step 000..111 every 3 cycles, done after 24 cycles, pass=1, err_count=0, fail_vec=8'h00.
REQ-031 Model with sum stuck at 0 -> fails vectors 1,2,4,7: fail_vec=8'b1001_0110, err_count=4, pass=0.
REQ-032 Model with cout inverted -> every vector fails: fail_vec=8'hFF, err_count=8, pass=0.
REQ-033 rst asserted during SETTLE of vector 3 -> next cycle IDLE, outputs 000, busy=0, err_count=0, fail_vec=0; following start runs all 8 vectors from 000.
REQ-034 start held high through a run -> no restart while busy; DONE entered once, then next edge restarts with results cleared; start pulse in DONE after a failing run clears err_count/fail_vec on the start edge.
REQ-035 Model with one-cycle registered output delay, SETTLE_CYCLES=1 -> pass=1, err_count=0 after 16 cycles.
